// File: rtl/switch_led_io_pkg.sv
// Shared definitions for the front-panel switch/LED block.
//   led_mode_e : LED display mode encodings driven on the mode input
//   clog2      : ceiling log2, used to size counters from parameters
package switch_led_io_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT = 2'd0,
        MODE_INVERT = 2'd1,
        MODE_TOGGLE = 2'd2,
        MODE_BLINK  = 2'd3
    } led_mode_e;

    // Returns 0 for values 0 and 1, so callers must clamp widths to >= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/switch_led_io_if.sv
// Front-panel bus between the board pins / core logic and switch_led_io.
//   switches     : raw asynchronous switch pins
//   mode         : LED display mode (see led_mode_e)
//   leds         : registered LED drive
//   switch_state : debounced switch level
//   rise / fall  : one-cycle debounced edge events
// master = board/core side, slave = switch_led_io.
interface switch_led_io_if #(
    parameter int unsigned CHANNELS = 4
);
    logic [CHANNELS-1:0] switches;
    logic [1:0]          mode;
    logic [CHANNELS-1:0] leds;
    logic [CHANNELS-1:0] switch_state;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;

    modport master (
        output switches, mode,
        input  leds, switch_state, rise, fall
    );

    modport slave (
        input  switches, mode,
        output leds, switch_state, rise, fall
    );
endinterface

// File: rtl/switch_led_io_debounce_channel.sv
// One switch channel: 2-flop synchroniser, debounce counter, stable level,
// rise/fall event pulses and a press-toggle bit.
//   clock, reset : system clock, async active-high reset
//   pin          : raw asynchronous switch pin
//   state        : debounced level
//   rise, fall   : one-cycle pulses on the edge that updates state
//   toggle       : flips on the edge after each rise pulse
module switch_led_io_debounce_channel
    import switch_led_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic state,
    output logic rise,
    output logic fall,
    output logic toggle
);

    localparam int unsigned CntW = (clog2(DEBOUNCE_CYCLES + 1) > 0) ?
                                   clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    logic            sync_meta;
    logic            sync;
    logic [CntW-1:0] count;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= pin;
            sync      <= sync_meta;
        end
    end

    // The counter only advances while the synchronised level disagrees with
    // the stable level; any agreeing sample restarts the qualification.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
            state <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync != state) begin
                if (count == CntLast) begin
                    state <= sync;
                    count <= '0;
                    rise  <= sync;
                    fall  <= ~sync;
                end else begin
                    count <= count + 1'b1;
                end
            end else begin
                count <= '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            toggle <= 1'b0;
        end else if (rise) begin
            toggle <= ~toggle;
        end
    end

endmodule

// File: rtl/switch_led_io.sv
// Front-panel I/O: debounces CHANNELS switches, reports rise/fall events and
// drives CHANNELS LEDs in one of four run-time display modes.
//   clock, reset : system clock, async active-high reset
//   bus          : switch_led_io_if slave (switches, mode in; leds,
//                  switch_state, rise, fall out)
module switch_led_io
    import switch_led_io_pkg::*;
#(
    parameter int unsigned CHANNELS          = 4,
    parameter int unsigned DEBOUNCE_CYCLES   = 16,
    parameter int unsigned BLINK_HALF_PERIOD = 1000
) (
    input logic           clock,
    input logic           reset,
    switch_led_io_if.slave bus
);

    localparam int unsigned BlinkW = (clog2(BLINK_HALF_PERIOD) > 0) ?
                                     clog2(BLINK_HALF_PERIOD) : 1;
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_HALF_PERIOD - 1);

    logic [CHANNELS-1:0] state;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] toggle;
    logic [CHANNELS-1:0] leds;
    logic [BlinkW-1:0]   blink_count;
    logic                blink_phase;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_channel
        switch_led_io_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce_channel (
            .clock (clock),
            .reset (reset),
            .pin   (bus.switches[i]),
            .state (state[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .toggle(toggle[i])
        );
    end

    // Shared free-running blink timebase; never gated by mode so the phase
    // stays coherent when switching in and out of blink mode.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_count <= '0;
            blink_phase <= 1'b0;
        end else if (blink_count == BlinkLast) begin
            blink_count <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_count <= blink_count + 1'b1;
        end
    end

    // mode is quasi-static and sampled directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            leds <= '0;
        end else begin
            case (led_mode_e'(bus.mode))
                MODE_DIRECT: leds <= state;
                MODE_INVERT: leds <= ~state;
                MODE_TOGGLE: leds <= toggle;
                MODE_BLINK:  leds <= state & {CHANNELS{blink_phase}};
                default:     leds <= state;
            endcase
        end
    end

    assign bus.leds         = leds;
    assign bus.switch_state = state;
    assign bus.rise         = rise;
    assign bus.fall         = fall;

endmodule

// File: tb/tb_switch_led_io.sv
// Self-checking bench for switch_led_io: directed scenarios plus randomized
// switch/mode/reset traffic, checked every cycle against a behavioural model.
module tb_switch_led_io;

    localparam int unsigned CH  = 4;
    localparam int unsigned DB  = 4;
    localparam int unsigned BHP = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;

    switch_led_io_if #(.CHANNELS(CH)) bus ();

    switch_led_io #(
        .CHANNELS         (CH),
        .DEBOUNCE_CYCLES  (DB),
        .BLINK_HALF_PERIOD(BHP)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model. pin_hist[j] is the pin value sampled j edges ago
    // (0 = this edge). A level is accepted once the debouncer has seen DB
    // consecutive synchronised samples (pins sampled 2..DB+1 edges ago) that
    // all differ from the stable level.
    logic [CH-1:0] pin_hist [0:DB+1];
    logic [CH-1:0] m_state, m_rise, m_fall, m_toggle, m_leds;
    int            m_edges;

    task automatic model_clear();
        for (int j = 0; j <= DB + 1; j++) pin_hist[j] = '0;
        m_state  = '0;
        m_rise   = '0;
        m_fall   = '0;
        m_toggle = '0;
        m_leds   = '0;
        m_edges  = 0;
    endtask

    task automatic model_edge();
        logic          phase;
        logic [CH-1:0] accept;
        if (reset) begin
            model_clear();
            return;
        end
        phase = ((m_edges / BHP) % 2) == 1;
        case (bus.mode)
            2'd0:    m_leds = m_state;
            2'd1:    m_leds = ~m_state;
            2'd2:    m_leds = m_toggle;
            default: m_leds = m_state & {CH{phase}};
        endcase
        m_toggle = m_toggle ^ m_rise;
        for (int j = DB + 1; j > 0; j--) pin_hist[j] = pin_hist[j-1];
        pin_hist[0] = bus.switches;
        accept = '1;
        for (int j = 2; j <= DB + 1; j++) accept = accept & (pin_hist[j] ^ m_state);
        m_rise  = accept & ~m_state;
        m_fall  = accept & m_state;
        m_state = m_state ^ accept;
        m_edges++;
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        check("leds", 32'(bus.leds), 32'(m_leds));
        check("switch_state", 32'(bus.switch_state), 32'(m_state));
        check("rise", 32'(bus.rise), 32'(m_rise));
        check("fall", 32'(bus.fall), 32'(m_fall));
        check("rise_fall_excl", 32'(bus.rise & bus.fall), 32'd0);
    endtask

    task automatic watch(input logic [CH-1:0] exp, input bit on_fall, input int steps,
                         output int first, output int count);
        logic [CH-1:0] sig;
        first = 0;
        count = 0;
        for (int k = 1; k <= steps; k++) begin
            step();
            sig = on_fall ? bus.fall : bus.rise;
            if (sig == exp) begin
                count++;
                if (first == 0) first = k;
            end
        end
    endtask

    int first, count, on_cnt;
    logic [2:0] toggle_exp;

    initial begin
        model_clear();
        bus.switches = '0;
        bus.mode     = 2'd0;
        reset        = 1'b1;

        // Reset and idle.
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        check("idle_state", 32'(bus.switch_state), 32'd0);
        bus.mode = 2'd1;
        step();
        check("mode1_leds", 32'(bus.leds), 32'hF);
        bus.mode = 2'd0;
        repeat (2) step();

        // Clean press and release on channel 0.
        bus.switches = 4'b0001;
        watch(4'b0001, 1'b0, 12, first, count);
        check("press_latency", 32'(first), 32'd6);
        check("press_pulses", 32'(count), 32'd1);
        check("press_led", 32'(bus.leds[0]), 32'd1);
        bus.switches = 4'b0000;
        watch(4'b0001, 1'b1, 12, first, count);
        check("release_latency", 32'(first), 32'd6);
        check("release_pulses", 32'(count), 32'd1);

        // Glitch of 3 cycles is discarded, 4 cycles is accepted.
        bus.switches = 4'b0010;
        repeat (3) step();
        bus.switches = 4'b0000;
        watch(4'b0010, 1'b0, 10, first, count);
        check("glitch_rise", 32'(count), 32'd0);
        check("glitch_state", 32'(bus.switch_state), 32'd0);
        count = 0;
        bus.switches = 4'b0010;
        for (int k = 0; k < 14; k++) begin
            if (k == 4) bus.switches = 4'b0000;
            step();
            if (bus.rise == 4'b0010) count++;
        end
        check("min_pulse_rise", 32'(count), 32'd1);
        repeat (6) step();

        // Toggle mode on channel 2.
        bus.mode   = 2'd2;
        toggle_exp = 3'b101;
        for (int p = 0; p < 3; p++) begin
            bus.switches = 4'b0100;
            repeat (9) step();
            check("toggle_led", 32'(bus.leds[2]), 32'(toggle_exp[p]));
            bus.switches = 4'b0000;
            repeat (9) step();
        end
        bus.mode = 2'd0;
        repeat (3) step();
        bus.mode = 2'd2;
        repeat (2) step();
        check("toggle_retained", 32'(bus.leds[2]), 32'd1);

        // Blink mode.
        bus.mode     = 2'd3;
        bus.switches = 4'b1010;
        repeat (9) step();
        on_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            if (bus.leds == 4'b1010) on_cnt++;
        end
        check("blink_on_cycles", 32'(on_cnt), 32'd8);
        bus.switches = 4'b0000;
        repeat (9) step();
        on_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.leds != 4'b0000) on_cnt++;
        end
        check("blink_off", 32'(on_cnt), 32'd0);

        // Reset in the middle of a debounce.
        bus.mode = 2'd0;
        repeat (3) step();
        bus.switches = 4'b1000;
        repeat (2) step();
        reset = 1'b1;
        #1;
        check("async_reset_state", 32'(bus.switch_state), 32'd0);
        watch(4'b1000, 1'b0, 3, first, count);
        check("reset_no_rise", 32'(count), 32'd0);
        reset = 1'b0;
        watch(4'b1000, 1'b0, 12, first, count);
        check("post_reset_latency", 32'(first), 32'd6);
        check("post_reset_pulses", 32'(count), 32'd1);

        // Randomized traffic.
        for (int it = 0; it < 400; it++) begin
            int hold;
            hold = int'($urandom_range(1, 7));
            bus.switches = bus.switches ^ CH'($urandom_range(0, 15) & $urandom_range(0, 15));
            if ($urandom_range(0, 9) == 0) bus.mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            repeat (hold) step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_led_io.md
Name: switch_led_io

Overview:
Parametrised front-panel I/O block that replaces the direct switch-to-LED wiring.
- Synchronises and debounces N mechanical switch inputs.
- Produces one-cycle rise/fall event pulses per switch.
- Drives N LEDs in one of four run-time-selectable display modes.
- Sits between board pins and core logic; its debounced state and event outputs feed downstream control.

Parameters:
CHANNELS, 4, number of switch/LED pairs (>=1)
DEBOUNCE_CYCLES, 16, consecutive cycles a synchronised input must differ from the stable value before it is accepted (>=1)
BLINK_HALF_PERIOD, 1000, clock cycles per blink phase (>=1)

Ports:
clock  input  1  system clock; all state on rising edge
reset  input  1  asynchronous, active-high reset
switches  input  CHANNELS  raw asynchronous switch pins
mode  input  2  LED mode: 0 direct, 1 inverted, 2 toggle, 3 blink-while-on
leds  output  CHANNELS  registered LED drive
switch_state  output  CHANNELS  debounced switch level
rise  output  CHANNELS  one-cycle pulse on debounced 0->1
fall  output  CHANNELS  one-cycle pulse on debounced 1->0

Behaviour:
- Reset (async assert, released synchronously by the board) clears the following to 0:
  - sync flops, debounce counters, switch_state, rise, fall, toggle bits, blink counter, blink phase, leds.
- Synchroniser: 2 flops per channel. sync[i] reflects switches[i] 2 edges after a change.
- Debounce, per channel, counter width clog2(DEBOUNCE_CYCLES+1):
  - If sync != switch_state: counter increments.
  - On the edge where counter == DEBOUNCE_CYCLES-1 and the mismatch persists: switch_state <= sync, counter <= 0.
  - If sync == switch_state: counter <= 0. Any glitch shorter than DEBOUNCE_CYCLES is fully discarded.
  - Latency from a clean pin change to switch_state change: 2 + DEBOUNCE_CYCLES edges.
  - DEBOUNCE_CYCLES=1 means switch_state follows sync with 1 cycle delay.
- Events: rise[i]/fall[i] are registered on the same edge that updates switch_state[i].
  - Each is high for exactly one cycle; never both high together.
  - Channels are independent; simultaneous events on several channels are all reported.
- Toggle bit: flips on each rise[i], i.e. on the edge after rise is seen.
- Blink timebase, shared by all channels:
  - Counter runs 0..BLINK_HALF_PERIOD-1 and wraps.
  - blink_phase inverts on each wrap.
  - Free-running from reset, independent of mode.
- LEDs are registered, so each update lands 1 cycle after its source:
  - mode 0: leds[i] <= switch_state[i]
  - mode 1: leds[i] <= ~switch_state[i]
  - mode 2: leds[i] <= toggle[i]
  - mode 3: leds[i] <= switch_state[i] & blink_phase
- Mode changes take effect on the next edge. Toggle bits and the blink counter are preserved across mode changes.
- mode is assumed quasi-static; it is sampled synchronously without synchronisation.
- Reset mid-debounce discards the partial count. After release the block restarts from switch_state=0:
  - A switch held high at release produces one rise after 2+DEBOUNCE_CYCLES cycles.
- In mode 1, leds go to all-ones 1 cycle after reset release.

Decomposition:
- Shared package: LED mode encodings (MODE_DIRECT=0, MODE_INVERT=1, MODE_TOGGLE=2, MODE_BLINK=3) and a clog2 helper function.
- Sub-module debounce_channel, instanced CHANNELS times via generate. It contains:
  - the synchroniser, counter, stable flop, rise/fall and toggle bit.
  - parameter DEBOUNCE_CYCLES.
- Top level holds the blink timebase and the LED mode mux.

Test Plan:
Bench configuration: CHANNELS=4, DEBOUNCE_CYCLES=4, BLINK_HALF_PERIOD=4, mode=0 unless stated.
- Reset then idle, switches=0000 -> leds, switch_state, rise, fall all 0000 during and after reset. Set mode=1 -> leds=1111 one cycle later.
- Clean press, switches[0] 0->1 and held -> rise=0001 for exactly 1 cycle, 6 edges after the pin change; switch_state[0]=1 on the same edge; leds[0]=1 one cycle later. Release -> fall=0001 six edges after release.
- Glitch, switches[1] high for 3 cycles then low -> switch_state, rise and leds unchanged. Held high for 4 cycles -> accepted.
- Toggle, mode=2 with three clean presses/releases on switches[2] -> leds[2] sequence 1,0,1 after each press. Switch to mode=0 and back to mode=2 -> leds[2]=1 is retained.
- Blink, mode=3 with switches=1010 held -> leds alternates 0000/1010, each phase 4 cycles. switches=0000 -> leds stays 0000.
- Reset mid-debounce: assert reset 2 cycles into a press on switches[3] -> no rise; all outputs 0. Release with the switch held -> rise=1000 six edges later.
